load_store_buffer: RTL
======================

// Module: load_store_buffer
// PURPOSE
//  In-order queue for loads/stores; producer end of the ls CDB (in_ls_cdb_rob_tag/in_ls_cdb_data at reservation stations).
//  Captures operands from decoder and both CDBs, computes addresses, runs one memory access at a time, broadcasts load results.
//  Sits between decoder/ROB and the memory controller.
// PARAMETERS
//  LSB_SIZE   8  queue depth (power of 2)
//  LSB_WIDTH  3  log2(LSB_SIZE); head/tail pointer width
// PORTS
//  clk               in   1            clock
//  rst               in   1            synchronous, active-high reset
//  assignment_ena    in   1            allocate entry at tail this cycle
//  in_op             in   `OPERATION_BUS LB/LH/LW/LBU/LHU/SB/SH/SW
//  in_Qj,in_Qk       in   `ROB_WIDTH   base/store-data tags; `ZERO_ROB = value valid
//  in_Vj,in_Vk       in   `DATA_WIDTH  base/store-data values
//  in_imm            in   `DATA_WIDTH  address offset
//  in_rd_rob         in   `ROB_WIDTH   owning ROB tag (never `ZERO_ROB)
//  in_alu_cdb_rob_tag,in_alu_cdb_data  in  ALU broadcast snoop
//  in_commit_store_rob in  `ROB_WIDTH  ROB tag of store now committing; `ZERO_ROB = none
//  in_rollback       in   1            flush all entries
//  out_mem_req       out  1            request valid; held until in_mem_done
//  out_mem_we        out  1            1=store
//  out_mem_addr      out  `DATA_WIDTH  Vj+imm, wraps mod 2^32
//  out_mem_size      out  2            0=byte 1=half 2=word
//  out_mem_wdata     out  `DATA_WIDTH  store data (low bytes)
//  in_mem_done       in   1            access complete (1-cycle pulse)
//  in_mem_rdata      in   `DATA_WIDTH  raw load data, valid with in_mem_done
//  out_ls_cdb_rob_tag out `ROB_WIDTH   load result tag; `ZERO_ROB = idle
//  out_ls_cdb_data   out  `DATA_WIDTH  sign/zero-extended load result
//  out_store_done    out  1            1-cycle pulse, store at head retired
//  out_has_capacity  out  1            count < LSB_SIZE
// BEHAVIOUR
//  Reset: head=tail=count=0, busy cleared, FSM=IDLE, all outputs 0 (out_ls_cdb_rob_tag=`ZERO_ROB), out_has_capacity=1.
//  Allocate: writes tail, tail++ (wraps), count++. Decoder asserts only when out_has_capacity=1; allocation when full ignored.
//  Alloc bypass: in_Qj/in_Qk equal to a nonzero CDB tag (ALU or own ls) this cycle -> store CDB data, tag `ZERO_ROB.
//  Snoop: every busy entry matching either CDB tag takes its data next edge; ALU and ls match same cycle -> ls wins.
//  Head ready: Qj=`ZERO_ROB and, for stores, Qk=`ZERO_ROB.
//  FSM IDLE: ready load at head -> assert req, go WAIT. Ready store -> wait until in_commit_store_rob == head tag, then req, WAIT.
//  FSM WAIT: outputs stable; on in_mem_done drop req; load -> next cycle ls CDB = {tag, extended data} for exactly 1 cycle;
//   store -> out_store_done 1 cycle. Head++, count-- that edge. Back to IDLE; next request no earlier than cycle after done.
//  Alloc+retire same edge: count unchanged. Full+retire: new allocation allowed that cycle (capacity reflects registered count).
//  Rollback: clear busy, head=tail, count=0 next edge. In WAIT: keep req to in_mem_done, then discard (no CDB, no store_done).
//   Committed store in flight is not rolled back at the memory side (finishes, discarded silently).
//  Extension: LB/LH sign-extend, LBU/LHU zero-extend, LW passthrough; sub-word data in in_mem_rdata low bits.
// CONFIGURATION
//  `LSB_ALIGN_CHECK_EN defined: misaligned half/word address at head -> no memory request; load broadcasts data 0
//   plus out_ls_cdb_exc=1 (extra 1-bit port); store pulses out_store_done with out_ls_cdb_exc=1.
//  Undefined: no check, no out_ls_cdb_exc port, addr passed unmodified to memory.
// STRUCTURE
//  constant.v: op encodings LB..SW, `ZERO_ROB, `ROB_WIDTH, `DATA_WIDTH, `OPERATION_BUS, size codes.
//  Sub-module load_extend (combinational: op + raw data -> extended word); remainder incl. FSM in this module.
// TESTING
//  LW ready at alloc, Vj=0x100 imm=4 tag=3 -> req addr 0x104 size 2; done rdata 0xDEADBEEF -> tag 3, data 0xDEADBEEF, 1 cycle.
//  LB Qj=5; ALU CDB tag 5 data 0x10 two cycles later; rdata 0x80 -> addr 0x10+imm, result 0xFFFFFF80; LBU -> 0x00000080.
//  SW tag 2 ready, no commit 10 cycles -> no req; commit_store_rob=2 -> req we=1; done -> store_done pulse, no CDB.
//  Fill 8 entries -> capacity 0; retire+alloc same cycle -> count stays 8, order LW,LW,... preserved FIFO.
//  Rollback during WAIT with 3 entries -> req held until done, no broadcast, count 0, capacity 1.
//  Alloc with in_Qj equal to live ALU CDB tag 7 -> entry captures data, issues without further wait.

Source files
------------

// File: rtl/load_store_buffer_pkg.sv
// Shared widths, operation encodings and entry layout for the load/store buffer.
// Optional misalignment trap is enabled with LSB_ALIGN_CHECK_EN.
package load_store_buffer_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ROB_WIDTH  = 5;
    localparam int OP_WIDTH   = 4;

    localparam logic [ROB_WIDTH-1:0] ZERO_ROB = '0;

    localparam logic [OP_WIDTH-1:0] OP_LB  = 4'd1;
    localparam logic [OP_WIDTH-1:0] OP_LH  = 4'd2;
    localparam logic [OP_WIDTH-1:0] OP_LW  = 4'd3;
    localparam logic [OP_WIDTH-1:0] OP_LBU = 4'd4;
    localparam logic [OP_WIDTH-1:0] OP_LHU = 4'd5;
    localparam logic [OP_WIDTH-1:0] OP_SB  = 4'd6;
    localparam logic [OP_WIDTH-1:0] OP_SH  = 4'd7;
    localparam logic [OP_WIDTH-1:0] OP_SW  = 4'd8;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef struct packed {
        logic [OP_WIDTH-1:0]   op;
        logic [ROB_WIDTH-1:0]  qj;
        logic [ROB_WIDTH-1:0]  qk;
        logic [DATA_WIDTH-1:0] vj;
        logic [DATA_WIDTH-1:0] vk;
        logic [DATA_WIDTH-1:0] imm;
        logic [ROB_WIDTH-1:0]  rob;
    } lsb_entry_t;

    function automatic logic is_store(input logic [OP_WIDTH-1:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic [1:0] op_size(input logic [OP_WIDTH-1:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SIZE_BYTE;
            OP_LH, OP_LHU, OP_SH: return SIZE_HALF;
            default:              return SIZE_WORD;
        endcase
    endfunction

endpackage

// File: rtl/load_store_buffer_load_extend.sv
// Combinational load result formatting: sign/zero extension of the raw
// memory word according to the load operation.
module load_extend
    import load_store_buffer_pkg::*;
(
    input  logic [OP_WIDTH-1:0]   op,
    input  logic [DATA_WIDTH-1:0] raw,
    output logic [DATA_WIDTH-1:0] ext
);

    always_comb begin
        case (op)
            OP_LB:   ext = {{24{raw[7]}}, raw[7:0]};
            OP_LH:   ext = {{16{raw[15]}}, raw[15:0]};
            OP_LBU:  ext = {24'd0, raw[7:0]};
            OP_LHU:  ext = {16'd0, raw[15:0]};
            default: ext = raw;
        endcase
    end

endmodule

// File: rtl/load_store_buffer.sv
// In-order load/store queue: operand capture from decoder and CDBs, one memory
// access at a time, load result broadcast. Optional feature macro: LSB_ALIGN_CHECK_EN.
module load_store_buffer
    import load_store_buffer_pkg::*;
#(
    parameter int LSB_SIZE  = 8,
    parameter int LSB_WIDTH = 3
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  assignment_ena,
    input  logic [OP_WIDTH-1:0]   in_op,
    input  logic [ROB_WIDTH-1:0]  in_Qj,
    input  logic [ROB_WIDTH-1:0]  in_Qk,
    input  logic [DATA_WIDTH-1:0] in_Vj,
    input  logic [DATA_WIDTH-1:0] in_Vk,
    input  logic [DATA_WIDTH-1:0] in_imm,
    input  logic [ROB_WIDTH-1:0]  in_rd_rob,
    input  logic [ROB_WIDTH-1:0]  in_alu_cdb_rob_tag,
    input  logic [DATA_WIDTH-1:0] in_alu_cdb_data,
    input  logic [ROB_WIDTH-1:0]  in_commit_store_rob,
    input  logic                  in_rollback,
    output logic                  out_mem_req,
    output logic                  out_mem_we,
    output logic [DATA_WIDTH-1:0] out_mem_addr,
    output logic [1:0]            out_mem_size,
    output logic [DATA_WIDTH-1:0] out_mem_wdata,
    input  logic                  in_mem_done,
    input  logic [DATA_WIDTH-1:0] in_mem_rdata,
    output logic [ROB_WIDTH-1:0]  out_ls_cdb_rob_tag,
    output logic [DATA_WIDTH-1:0] out_ls_cdb_data,
    output logic                  out_store_done,
`ifdef LSB_ALIGN_CHECK_EN
    output logic                  out_ls_cdb_exc,
`endif
    output logic                  out_has_capacity
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;
    localparam logic [LSB_WIDTH:0] FULL_COUNT = LSB_SIZE[LSB_WIDTH:0];

    lsb_entry_t             entries [LSB_SIZE];
    logic [LSB_SIZE-1:0]    busy;
    logic [LSB_WIDTH-1:0]   head, tail;
    logic [LSB_WIDTH:0]     count;
    logic [0:0]             state;
    logic                   discard;

    lsb_entry_t             head_entry, alloc_entry;
    logic [DATA_WIDTH-1:0]  head_addr, ext_data;
    logic                   head_store, head_ready, start, misaligned, retire, alloc;

    load_extend u_load_extend (
        .op  (head_entry.op),
        .raw (in_mem_rdata),
        .ext (ext_data)
    );

    assign out_has_capacity = (count != FULL_COUNT);

    always_comb begin
        head_entry = entries[head];
        head_addr  = head_entry.vj + head_entry.imm;
        head_store = is_store(head_entry.op);
        head_ready = busy[head] && (head_entry.qj == ZERO_ROB) &&
                     (!head_store || (head_entry.qk == ZERO_ROB));
        start      = (state == S_IDLE) && !in_rollback && head_ready &&
                     (!head_store || (in_commit_store_rob == head_entry.rob));
`ifdef LSB_ALIGN_CHECK_EN
        misaligned = ((op_size(head_entry.op) == SIZE_HALF) && head_addr[0]) ||
                     ((op_size(head_entry.op) == SIZE_WORD) && (head_addr[1:0] != 2'b00));
`else
        misaligned = 1'b0;
`endif
        retire = ((state == S_WAIT) && in_mem_done && !discard && !in_rollback) ||
                 (start && misaligned);
        // A retiring head frees its slot this edge, so a full queue may still accept.
        alloc  = assignment_ena && !in_rollback && (out_has_capacity || retire);
    end

    always_comb begin
        alloc_entry.op  = in_op;
        alloc_entry.qj  = in_Qj;
        alloc_entry.qk  = in_Qk;
        alloc_entry.vj  = in_Vj;
        alloc_entry.vk  = in_Vk;
        alloc_entry.imm = in_imm;
        alloc_entry.rob = in_rd_rob;
        if (in_Qj != ZERO_ROB && in_Qj == in_alu_cdb_rob_tag) begin
            alloc_entry.qj = ZERO_ROB;
            alloc_entry.vj = in_alu_cdb_data;
        end
        if (in_Qj != ZERO_ROB && in_Qj == out_ls_cdb_rob_tag) begin
            alloc_entry.qj = ZERO_ROB;
            alloc_entry.vj = out_ls_cdb_data;
        end
        if (in_Qk != ZERO_ROB && in_Qk == in_alu_cdb_rob_tag) begin
            alloc_entry.qk = ZERO_ROB;
            alloc_entry.vk = in_alu_cdb_data;
        end
        if (in_Qk != ZERO_ROB && in_Qk == out_ls_cdb_rob_tag) begin
            alloc_entry.qk = ZERO_ROB;
            alloc_entry.vk = out_ls_cdb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy               <= '0;
            head               <= '0;
            tail               <= '0;
            count              <= '0;
            state              <= S_IDLE;
            discard            <= 1'b0;
            out_mem_req        <= 1'b0;
            out_mem_we         <= 1'b0;
            out_mem_addr       <= '0;
            out_mem_size       <= '0;
            out_mem_wdata      <= '0;
            out_ls_cdb_rob_tag <= ZERO_ROB;
            out_ls_cdb_data    <= '0;
            out_store_done     <= 1'b0;
`ifdef LSB_ALIGN_CHECK_EN
            out_ls_cdb_exc     <= 1'b0;
`endif
        end else begin
            out_ls_cdb_rob_tag <= ZERO_ROB;
            out_ls_cdb_data    <= '0;
            out_store_done     <= 1'b0;
`ifdef LSB_ALIGN_CHECK_EN
            out_ls_cdb_exc     <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (start && misaligned) begin
                        if (head_store) begin
                            out_store_done <= 1'b1;
                        end else begin
                            out_ls_cdb_rob_tag <= head_entry.rob;
                        end
`ifdef LSB_ALIGN_CHECK_EN
                        out_ls_cdb_exc <= 1'b1;
`endif
                    end else if (start) begin
                        out_mem_req   <= 1'b1;
                        out_mem_we    <= head_store;
                        out_mem_addr  <= head_addr;
                        out_mem_size  <= op_size(head_entry.op);
                        out_mem_wdata <= head_entry.vk;
                        state         <= S_WAIT;
                    end
                end
                default: begin
                    // A flushed access still runs to completion; only its result is dropped.
                    if (in_mem_done) begin
                        out_mem_req <= 1'b0;
                        state       <= S_IDLE;
                        discard     <= 1'b0;
                        if (retire) begin
                            if (head_store) begin
                                out_store_done <= 1'b1;
                            end else begin
                                out_ls_cdb_rob_tag <= head_entry.rob;
                                out_ls_cdb_data    <= ext_data;
                            end
                        end
                    end else if (in_rollback) begin
                        discard <= 1'b1;
                    end
                end
            endcase

            // Operand snoop; the ls CDB is applied second so it wins a tie.
            for (int unsigned i = 0; i < LSB_SIZE; i++) begin
                if (busy[i]) begin
                    if (in_alu_cdb_rob_tag != ZERO_ROB && entries[i].qj == in_alu_cdb_rob_tag) begin
                        entries[i].qj <= ZERO_ROB;
                        entries[i].vj <= in_alu_cdb_data;
                    end
                    if (out_ls_cdb_rob_tag != ZERO_ROB && entries[i].qj == out_ls_cdb_rob_tag) begin
                        entries[i].qj <= ZERO_ROB;
                        entries[i].vj <= out_ls_cdb_data;
                    end
                    if (in_alu_cdb_rob_tag != ZERO_ROB && entries[i].qk == in_alu_cdb_rob_tag) begin
                        entries[i].qk <= ZERO_ROB;
                        entries[i].vk <= in_alu_cdb_data;
                    end
                    if (out_ls_cdb_rob_tag != ZERO_ROB && entries[i].qk == out_ls_cdb_rob_tag) begin
                        entries[i].qk <= ZERO_ROB;
                        entries[i].vk <= out_ls_cdb_data;
                    end
                end
            end

            if (retire) begin
                busy[head] <= 1'b0;
                head       <= head + 1'b1;
            end
            if (alloc) begin
                entries[tail] <= alloc_entry;
                busy[tail]    <= 1'b1;
                tail          <= tail + 1'b1;
            end
            case ({alloc, retire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase

            if (in_rollback) begin
                busy  <= '0;
                head  <= tail;
                count <= '0;
            end
        end
    end

endmodule
